coordinate_gen_scaled: RTL and testbench

//  Parametrised successor to the fixed 640x480 raster coordinate source. Emits one signed

---
 rtl/coord_pkg.sv | 24 ++
 rtl/raster_counter.sv | 46 ++++
 rtl/coordinate_gen_scaled.sv | 143 ++++++++++++++
 tb/tb_coordinate_gen_scaled.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/coord_pkg.sv
// Shared types and constants for the raster coordinate source: default widths,
// FSM state encoding and fixed-point helpers.
package coord_pkg;

    localparam int COORD_W_DEF = 32;
    localparam int FRAC_W_DEF  = 16;
    localparam int CNT_W_DEF   = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [31:0] ONE = 32'h0000_0001 << FRAC_W_DEF;

    // Integer value to fixed point with frac_w fractional bits (wraps to 32 bits).
    function automatic logic [31:0] to_fixed(input int value, input int frac_w);
        logic [31:0] v_s;
        v_s = 32'(value);
        return v_s << frac_w;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row raster counter with end-of-line and end-of-frame decode.
// Advances one pixel per 'advance', wraps to (0,0) after the last pixel.
module raster_counter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             clear,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             eol,
    output logic             eof
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(H_RES - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(V_RES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] col_r;
    logic [CNT_W-1:0] row_r;

    assign col = col_r;
    assign row = row_r;
    assign eol = (col_r == COL_LAST);
    assign eof = (col_r == COL_LAST) && (row_r == ROW_LAST);

    // Pixel/line position register.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            col_r <= CNT_ZERO;
            row_r <= CNT_ZERO;
        end else if (advance) begin
            if (eol) begin
                col_r <= CNT_ZERO;
                row_r <= eof ? CNT_ZERO : (row_r + CNT_ONE);
            end else begin
                col_r <= col_r + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/coordinate_gen_scaled.sv
// Raster-order signed fixed-point (x,y) stream generator with valid/ready handshake,
// programmable centre/step snapshotted once per frame, and SOF/EOL/EOF markers.
module coordinate_gen_scaled
    import coord_pkg::*;
#(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int COORD_W = COORD_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               continuous,
    input  logic [COORD_W-1:0] centre_x,
    input  logic [COORD_W-1:0] centre_y,
    input  logic [COORD_W-1:0] step,
    input  logic               ready,
    output logic               valid,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [CNT_W-1:0]   col,
    output logic [CNT_W-1:0]   row,
    output logic               sof,
    output logic               eol,
    output logic               eof,
    output logic               busy
);

    if (FRAC_W >= COORD_W || (H_RES % 2) != 0 || (V_RES % 2) != 0) begin : g_bad_params
        $error("coordinate_gen_scaled: invalid parameter set");
    end

    localparam logic [COORD_W-1:0] HALF_H     = COORD_W'(H_RES / 2);
    localparam logic [COORD_W-1:0] HALF_V     = COORD_W'(V_RES / 2);
    localparam logic [COORD_W-1:0] COORD_ZERO = {COORD_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};

    state_t             state_r;
    state_t             state_s;
    logic               busy_r;
    logic               valid_r;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic [COORD_W-1:0] x0_r;
    logic [COORD_W-1:0] step_r;
    logic [COORD_W-1:0] x0_s;
    logic [COORD_W-1:0] y0_s;
    logic               xfer_s;
    logic               cnt_eol_s;
    logic               cnt_eof_s;
    logic [CNT_W-1:0]   cnt_col_s;
    logic [CNT_W-1:0]   cnt_row_s;

    assign xfer_s = valid_r && ready;
    // Frame origin: left edge, top line (y grows upward, so the top is centre + half height).
    assign x0_s = centre_x - (step * HALF_H);
    assign y0_s = centre_y + (step * HALF_V);

    raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .CNT_W (CNT_W)
    ) u_raster (
        .clk     (clk),
        .reset   (reset),
        .advance (xfer_s),
        .clear   (state_r == ST_SETUP),
        .col     (cnt_col_s),
        .row     (cnt_row_s),
        .eol     (cnt_eol_s),
        .eof     (cnt_eof_s)
    );

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_RUN;
            end
            ST_RUN: begin
                if (xfer_s && cnt_eof_s) begin
                    state_s = continuous ? ST_SETUP : ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, status flags, shadow registers and coordinate accumulators.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            x_r     <= COORD_ZERO;
            y_r     <= COORD_ZERO;
            x0_r    <= COORD_ZERO;
            step_r  <= COORD_ZERO;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            valid_r <= (state_s == ST_RUN);
            if (state_r == ST_SETUP) begin
                x0_r   <= x0_s;
                step_r <= step;
                x_r    <= x0_s;
                y_r    <= y0_s;
            end else if (xfer_s) begin
                if (cnt_eol_s) begin
                    x_r <= x0_r;
                    y_r <= y_r - step_r;
                end else begin
                    x_r <= x_r + step_r;
                end
            end
        end
    end

    assign valid = valid_r;
    assign busy  = busy_r;
    assign x     = x_r;
    assign y     = y_r;
    assign col   = cnt_col_s;
    assign row   = cnt_row_s;
    assign sof   = valid_r && (cnt_col_s == CNT_ZERO) && (cnt_row_s == CNT_ZERO);
    assign eol   = valid_r && cnt_eol_s;
    assign eof   = valid_r && cnt_eof_s;

endmodule

// File: tb/tb_coordinate_gen_scaled.sv
// Directed self-checking bench for coordinate_gen_scaled on a 4x2 raster, Q8.8 coordinates.
module tb_coordinate_gen_scaled;
    import coord_pkg::*;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int CW = 16;
    localparam int FW = 8;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          continuous;
    logic          ready;
    logic [CW-1:0] centre_x;
    logic [CW-1:0] centre_y;
    logic [CW-1:0] step;
    logic          valid;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [NW-1:0] col;
    logic [NW-1:0] row;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [CW-1:0] exp_x [4];
    logic [CW-1:0] exp_y [2];
    logic          pat   [4];

    always #5 clk = ~clk;

    coordinate_gen_scaled #(
        .H_RES   (H),
        .V_RES   (V),
        .COORD_W (CW),
        .FRAC_W  (FW),
        .CNT_W   (NW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
        .centre_x   (centre_x),
        .centre_y   (centre_y),
        .step       (step),
        .ready      (ready),
        .valid      (valid),
        .x          (x),
        .y          (y),
        .col        (col),
        .row        (row),
        .sof        (sof),
        .eol        (eol),
        .eof        (eof),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_beat(input string tag, input int b);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_x"},     32'(x),     32'(exp_x[b % H]));
        chk({tag, "_y"},     32'(y),     32'(exp_y[b / H]));
        chk({tag, "_col"},   32'(col),   32'(b % H));
        chk({tag, "_row"},   32'(row),   32'(b / H));
        chk({tag, "_sof"},   32'(sof),   32'(b == 0));
        chk({tag, "_eol"},   32'(eol),   32'((b % H) == (H - 1)));
        chk({tag, "_eof"},   32'(eof),   32'(b == (H * V - 1)));
    endtask

    initial begin
        int b;
        int nx;

        // Reset with start held high: reset wins.
        reset = 1'b1; start = 1'b1; continuous = 1'b0; ready = 1'b1;
        centre_x = 16'h0000; centre_y = 16'h0000; step = 16'h0000;
        tick(); tick();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_x",     32'(x),     32'd0);
        chk("rst_y",     32'(y),     32'd0);
        chk("rst_col",   32'(col),   32'd0);
        chk("rst_sof",   32'(sof),   32'd0);
        reset = 1'b0; start = 1'b0;
        tick(); tick();
        chk("idle_valid", 32'(valid), 32'd0);
        chk("idle_busy",  32'(busy),  32'd0);

        // Frame 1: centre 0, step 1.0, full throughput; a stray start mid-frame is ignored.
        step  = CW'(to_fixed(1, FW));
        exp_x = '{16'hFE00, 16'hFF00, 16'h0000, 16'h0100};
        exp_y = '{16'h0100, 16'h0000};
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("f1_setup_busy",  32'(busy),  32'd1);
        chk("f1_setup_valid", 32'(valid), 32'd0);
        tick();
        for (int i = 0; i < H * V; i++) begin
            check_beat("f1", i);
            start = (i == 3) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        chk("f1_end_valid", 32'(valid), 32'd0);
        chk("f1_end_busy",  32'(busy),  32'd0);
        chk("f1_end_eof",   32'(eof),   32'd0);

        // Same frame with ready toggling 1,0,0,1: held beats stay identical.
        start = 1'b1; tick(); start = 1'b0; tick();
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        b = 0; nx = 0;
        for (int c = 0; c < 64 && b < H * V; c++) begin
            ready = pat[c % 4];
            check_beat("hs", b);
            if (valid && ready) nx++;
            if (ready) b++;
            tick();
        end
        ready = 1'b1;
        chk("hs_xfers",     32'(nx),    32'd8);
        chk("hs_end_valid", 32'(valid), 32'd0);
        chk("hs_end_busy",  32'(busy),  32'd0);

        // Continuous: centre_x changed mid-frame only affects the next frame.
        continuous = 1'b1;
        start = 1'b1; tick(); start = 1'b0; tick();
        for (int i = 0; i < H * V; i++) begin
            check_beat("c1", i);
            if (i == 2) centre_x = 16'h0200;
            tick();
        end
        chk("c_bubble_valid", 32'(valid), 32'd0);
        chk("c_bubble_busy",  32'(busy),  32'd1);
        chk("c_bubble_sof",   32'(sof),   32'd0);
        continuous = 1'b0;
        exp_x = '{16'h0000, 16'h0100, 16'h0200, 16'h0300};
        tick();
        for (int i = 0; i < H * V; i++) begin
            check_beat("c2", i);
            tick();
        end
        chk("c2_end_busy", 32'(busy), 32'd0);

        // Wrap-around arithmetic.
        centre_x = 16'h7F00; step = 16'h4000;
        exp_x = '{16'hFF00, 16'h3F00, 16'h7F00, 16'hBF00};
        exp_y = '{16'h4000, 16'h0000};
        start = 1'b1; tick(); start = 1'b0; tick();
        for (int i = 0; i < H * V; i++) begin
            check_beat("wr", i);
            tick();
        end
        chk("wr_end_busy", 32'(busy), 32'd0);

        // Reset on beat 5, then a clean restart.
        centre_x = 16'h0000; step = 16'h0100;
        exp_x = '{16'hFE00, 16'hFF00, 16'h0000, 16'h0100};
        exp_y = '{16'h0100, 16'h0000};
        start = 1'b1; tick(); start = 1'b0; tick();
        for (int i = 0; i < 5; i++) begin
            check_beat("mr", i);
            tick();
        end
        check_beat("mr", 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_valid", 32'(valid), 32'd0);
        chk("mr_busy",  32'(busy),  32'd0);
        chk("mr_x",     32'(x),     32'd0);
        chk("mr_col",   32'(col),   32'd0);
        tick(); tick();
        chk("mr_quiet_valid", 32'(valid), 32'd0);
        start = 1'b1; tick(); start = 1'b0; tick();
        for (int i = 0; i < H * V; i++) begin
            check_beat("rs", i);
            tick();
        end
        chk("rs_end_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
